pwm_ramp_controller: RTL and testbench
======================================

# pwm_ramp_controller

Avalon-MM slave that owns and sequences one PWM output channel for the Nios II media-computer system, such as the green-LED PWM. Software programs the period, a target duty, and a ramp step and rate. The block runs the PWM counter and moves the active duty toward the target in controlled steps, always at period boundaries so the output never glitches. It raises a maskable interrupt when a ramp completes.

## Interface
- CNT_W, 16: width of period, duty, step and counter.
- RATE_W, 16: width of the ramp-rate register and its counter.

- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- avs_address  in  3  register select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data; unused upper bits are ignored.
- avs_readdata  out  32  read data, zero-extended.
- irq  out  1  interrupt, level, active-high.
- pwm_out  out  1  PWM waveform.

Register map:
- 0 CTRL: [0] EN, [1] IRQ_EN, [2] POL (invert output).
- 1 PERIOD: shadow.
- 2 TARGET: shadow.
- 3 STEP
- 4 RATE
- 5 STATUS: [0] RAMPING (read-only), [1] DONE (sticky, write 1 to clear).
- 6 DUTY: active duty, read-only.
- 7: reserved; reads 0.

## Operation
- Reset: all registers, period_act, duty_act, cnt and rate_cnt go to 0. FSM goes to IDLE. pwm_out=0, irq=0, avs_readdata=0.
- FSM states: IDLE, HOLD, RAMP.
  - IDLE: entered whenever EN=0. cnt is held at 0. pwm_out=POL. duty_act is retained.
  - IDLE→HOLD or RAMP when EN=1: goes to RAMP if duty_act≠TARGET, else HOLD.
- Period counter:
  - cnt runs 0..period_act−1 and then wraps.
  - A period boundary is the cycle where cnt==period_act−1, plus the first cycle after leaving IDLE.
  - At every boundary, period_act is reloaded from PERIOD.
  - If period_act==0, cnt is held at 0 and every cycle counts as a boundary.
- Output: pwm_out = ((cnt < duty_act) XOR POL) while in HOLD or RAMP.
  - duty_act ≥ period_act gives a constant-active output.
  - duty_act = 0 gives a constant-inactive output.
- Ramp engine: evaluated only at boundaries while in RAMP.
  - If rate_cnt < RATE: rate_cnt increments.
  - Otherwise rate_cnt goes to 0 and duty_act steps toward TARGET by max(STEP,1).
  - A step that would reach or cross TARGET sets duty_act=TARGET exactly. No overshoot or wrap; arithmetic uses CNT_W+1 bits.
  - RATE=0 gives one step per period.
- RAMP→HOLD when duty_act becomes equal to TARGET. On that transition DONE is set.
- HOLD→RAMP at the next boundary after TARGET≠duty_act. A TARGET write during RAMP retargets at the next step with no restart.
- rate_cnt is cleared on entering RAMP.
- STATUS.RAMPING is 1 iff state==RAMP.
- irq = DONE AND IRQ_EN.
- DONE set and a W1C clear in the same cycle: set wins.
- EN cleared mid-ramp: next cycle the FSM is in IDLE and pwm_out=POL. duty_act is frozen. Re-enabling resumes the ramp from the frozen value.

## Timing
- Register writes are visible in the register the cycle after the avs_write cycle.
- Read latency is 1: avs_readdata is valid the cycle after avs_read and holds until the next read. No waitrequest.
- Enable:
  - Write CTRL.EN=1 at cycle T; EN=1 at T+1.
  - The FSM leaves IDLE at T+1. T+1 is the first boundary, where period_act loads and cnt=0.
  - pwm_out reflects the new period and duty from T+2.
- pwm_out is registered: one cycle after the cnt/duty_act compare.
- Shadow writes to PERIOD and TARGET never affect the current period. They act at the next boundary.
- DONE rises the cycle after the final step. irq follows in the same cycle DONE is visible.

## Test plan
- **Reset:** assert reset for 2 cycles with EN previously 1 → pwm_out=0, irq=0, every register reads 0 one cycle after each read strobe.
- **Steady PWM:** PERIOD=10, TARGET=3, STEP=3, RATE=0, EN=1 → at most one boundary to reach duty 3. Then pwm_out is high for 3 of every 10 cycles. POL=1 inverts to 7 of 10.
- **Ramp up with clamp:**
  - Setup: PERIOD=8, duty_act=0, TARGET=7, STEP=3, RATE=1.
  - Expected: duty_act goes 0→3→6→7, each change 2 periods apart.
  - DONE=1 and RAMPING=0 after reaching 7. irq=1 only if IRQ_EN=1.
- **Ramp down, retarget mid-ramp:**
  - Setup: duty_act=20, TARGET=0, STEP=5, RATE=0.
  - Action: write TARGET=12 while duty_act=15.
  - Expected: 15→12, DONE set.
- **Edge cases:**
  - PERIOD=0: pwm_out stays at POL.
  - TARGET≥PERIOD: output stays active.
  - Writing PERIOD mid-period: the old period completes first.
- **DONE set/clear collision and disable mid-ramp:**
  - Write STATUS=2 in the same cycle DONE is being set: DONE stays 1.
  - Clear EN mid-ramp: pwm_out=POL next cycle and DUTY is frozen. Re-enable: the ramp continues from the frozen value.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: Avalon-MM slave driving one PWM channel whose duty
// ramps toward a software target in fixed steps, applied only at period
// boundaries so the waveform never glitches. Raises a maskable interrupt
// when a ramp completes.
//
// Bus handshake: a read or write is accepted in every cycle its strobe is
// high (no waitrequest). Writes land in the register at the next edge;
// read data appears on avs_readdata one cycle after avs_read and holds
// until the next read.
module pwm_ramp_controller #(
  parameter int CNT_W  = 16,
  parameter int RATE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        pwm_out
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]    STEP_ONE = (CNT_W + 1)'(1);
  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Software-visible registers
  logic [2:0]        ctrl;
  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  step;
  logic [RATE_W-1:0] rate;
  logic              done;

  // Running state
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  duty_act;
  logic [CNT_W-1:0]  cnt;
  logic [RATE_W-1:0] rate_cnt;

  logic en, irq_en, pol;
  assign en     = ctrl[0];
  assign irq_en = ctrl[1];
  assign pol    = ctrl[2];

  // Only the low CNT_W/RATE_W bits of write data carry register content.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata[31:CNT_W]};

  logic             boundary;
  logic             ramp_tick;
  logic             rate_roll;
  logic             done_set;
  logic             done_clr;
  logic [CNT_W:0]   step_eff;
  logic [CNT_W:0]   sum_up;
  logic [CNT_W:0]   diff_dn;
  logic [CNT_W-1:0] duty_step;
  logic [CNT_W-1:0] duty_nxt;
  logic [CNT_W-1:0] period_cmp;
  logic             active;
  logic [31:0]      rd_mux;

  // Period boundary: last count of a period, every cycle when the period is
  // zero, and the cycle the block leaves IDLE.
  always_comb begin
    boundary = 1'b0;
    if (state == ST_IDLE) begin
      boundary = en;
    end else begin
      boundary = (period_act == '0) || (cnt == period_act - CNT_ONE);
    end
  end

  // Next duty value after one clamped step toward the target (CNT_W+1 bit math).
  always_comb begin
    step_eff  = (step == '0) ? STEP_ONE : {1'b0, step};
    sum_up    = {1'b0, duty_act} + step_eff;
    diff_dn   = {1'b0, duty_act} - {1'b0, target};
    duty_step = duty_act;
    if (duty_act < target) begin
      duty_step = (sum_up >= {1'b0, target}) ? target : sum_up[CNT_W-1:0];
    end else if (duty_act > target) begin
      duty_step = (diff_dn <= step_eff) ? target : (duty_act - step_eff[CNT_W-1:0]);
    end
  end

  assign ramp_tick = (state == ST_RAMP) && en && boundary;
  assign rate_roll = ramp_tick && (rate_cnt >= rate);
  assign duty_nxt  = rate_roll ? duty_step : duty_act;

  // Next-state logic; DONE is raised on the RAMP->HOLD transition.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = (duty_act != target) ? ST_RAMP : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (boundary && (duty_act != target)) begin
          state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (duty_nxt == target) begin
          state_nxt = ST_HOLD;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Software register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= '0;
      period_sh <= '0;
      target    <= '0;
      step      <= '0;
      rate      <= '0;
    end else if (avs_write) begin
      case (avs_address)
        3'd0:    ctrl      <= avs_writedata[2:0];
        3'd1:    period_sh <= avs_writedata[CNT_W-1:0];
        3'd2:    target    <= avs_writedata[CNT_W-1:0];
        3'd3:    step      <= avs_writedata[CNT_W-1:0];
        3'd4:    rate      <= avs_writedata[RATE_W-1:0];
        default: ;
      endcase
    end
  end

  assign done_clr = avs_write && (avs_address == 3'd5) && avs_writedata[1];

  // Sticky DONE flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (done_set) begin
      done <= 1'b1;
    end else if (done_clr) begin
      done <= 1'b0;
    end
  end

  // Period counter and period reload at boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      period_act <= '0;
    end else begin
      if ((state_nxt == ST_IDLE) || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      if (boundary) begin
        period_act <= period_sh;
      end
    end
  end

  // Ramp engine: rate divider and duty update
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_cnt <= '0;
      duty_act <= '0;
    end else begin
      if ((state != ST_RAMP) && (state_nxt == ST_RAMP)) begin
        rate_cnt <= '0;
      end else if (ramp_tick) begin
        rate_cnt <= rate_roll ? '0 : (rate_cnt + RATE_ONE);
      end
      duty_act <= duty_nxt;
    end
  end

  // While leaving IDLE the counter is at 0 and the new period is about to load,
  // so the shadow period is used for that one compare.
  assign period_cmp = (state == ST_IDLE) ? period_sh : period_act;
  assign active     = (period_cmp != '0) && (cnt < duty_act);

  // Registered PWM output; idle (and about-to-idle) drives the polarity level.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else if (state_nxt == ST_IDLE) begin
      pwm_out <= pol;
    end else begin
      pwm_out <= active ^ pol;
    end
  end

  // Read data selection, zero-extended
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux = 32'(ctrl);
      3'd1:    rd_mux = 32'(period_sh);
      3'd2:    rd_mux = 32'(target);
      3'd3:    rd_mux = 32'(step);
      3'd4:    rd_mux = 32'(rate);
      3'd5:    rd_mux = 32'({done, (state == ST_RAMP)});
      3'd6:    rd_mux = 32'(duty_act);
      default: rd_mux = '0;
    endcase
  end

  // Read data register: captured on a read strobe, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  assign irq = done && irq_en;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Testbench for pwm_ramp_controller: register reads are scoreboarded against
// a timeline model of the duty ramp built from the ramp rules with plain
// arithmetic; PWM output and irq are checked directly.
module tb_pwm_ramp_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        pwm_out;

  pwm_ramp_controller #(.CNT_W(16), .RATE_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pwm_out       (pwm_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  int seq_q[$];
  int cfg_p, cfg_t, cfg_s, cfg_r;
  bit cfg_pol, cfg_ie;
  int cur_duty;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) rd_seen <= avs_read && !reset;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string nm;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got %0d expected no read data", avs_readdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, avs_readdata, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input bit w, input bit r, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write     = w;
    avs_read      = r;
    avs_address   = a;
    avs_writedata = d;
  endtask

  task automatic wr(input logic [2:0] a, input int d);
    bus(1'b1, 1'b0, a, 32'(d));
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input int e, input string nm);
    bus(1'b0, 1'b1, a, 32'd0);
    exp_q.push_back(32'(e));
    name_q.push_back(nm);
  endtask

  function automatic int ctrl_word(input bit pol, input bit ie, input bit en);
    return (int'(pol) << 2) | (int'(ie) << 1) | int'(en);
  endfunction

  // ---------------- reference model ----------------
  // Duty values visited from start to target, one entry per applied step.
  function automatic void build_seq(input int start, input int tgt, input int stp);
    int cur;
    int eff;
    cur = start;
    eff = (stp == 0) ? 1 : stp;
    seq_q.delete();
    seq_q.push_back(cur);
    while (cur != tgt) begin
      if (cur < tgt) cur = (cur + eff >= tgt) ? tgt : cur + eff;
      else           cur = (cur - tgt <= eff) ? tgt : cur - eff;
      seq_q.push_back(cur);
    end
  endfunction

  // Duty during cycle j after enable (cycle 0 = first enabled cycle).
  // Steps land every q = (RATE+1)*PERIOD cycles, first visible at q+1.
  function automatic int seq_at(input int j, input int q);
    int idx;
    int n;
    n   = seq_q.size() - 1;
    idx = (j < 1) ? 0 : (j - 1) / q;
    if (idx > n) idx = n;
    return seq_q[idx];
  endfunction

  task automatic configure();
    wr(3'd0, ctrl_word(cfg_pol, cfg_ie, 1'b0));
    wr(3'd1, cfg_p);
    wr(3'd2, cfg_t);
    wr(3'd3, cfg_s);
    wr(3'd4, cfg_r);
    wr(3'd5, 2);
  endtask

  task automatic pwm_window(input string nm, input int p, input int d, input bit pol);
    int ones;
    int e;
    ones = 0;
    for (int k = 0; k < p; k++) begin
      idle();
      ones += int'(pwm_out);
    end
    e = (d < p) ? d : p;
    if (pol) e = p - e;
    check(nm, 32'(ones), 32'(e));
  endtask

  // Enable, read DUTY every cycle against the model, optionally disable at
  // jdis, retarget at jrt, or clear DONE exactly when it is being set.
  task automatic run_ramp(input int jdis, input bit collide, input int jrt, input int new_t);
    int  n, q, jdone, jend, frozen, fin;
    bit  trunc;
    configure();
    n      = seq_q.size() - 1;
    q      = (cfg_r + 1) * cfg_p;
    jdone  = n * q;
    trunc  = (jdis >= 0);
    jend   = trunc ? jdis + 2 : jdone + 3;
    frozen = trunc ? seq_at(jdis + 1, q) : 0;
    wr(3'd0, ctrl_word(cfg_pol, cfg_ie, 1'b1));
    for (int j = 0; j <= jend; j++) begin
      if (trunc && j == jdis)                 wr(3'd0, ctrl_word(cfg_pol, cfg_ie, 1'b0));
      else if (j == jrt)                      wr(3'd2, new_t);
      else if (collide && n > 0 && j == jdone) wr(3'd5, 2);
      else                                    rd(3'd6, (trunc && j > jdis) ? frozen : seq_at(j, q), "duty");
      if (trunc && j == jdis + 2) check("pwm_pol_after_disable", 32'(pwm_out), 32'(cfg_pol));
    end
    idle();
    if (trunc) begin
      cur_duty = frozen;
      rd(3'd5, 0, "status_disabled");
      idle();
      idle();
      check("irq_disabled", 32'(irq), 32'd0);
    end else begin
      fin      = seq_q[n];
      cur_duty = fin;
      rd(3'd5, (n > 0) ? 2 : 0, "status_done");
      idle();
      idle();
      check("irq_done", 32'(irq), 32'((n > 0) && cfg_ie));
      pwm_window("pwm_window", cfg_p, fin, cfg_pol);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int  n, q, jdis;
    bit  trunc, collide, last_trunc;
    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Reset while enabled and DONE/irq active
    cfg_p = 6; cfg_t = 4; cfg_s = 2; cfg_r = 0; cfg_pol = 1'b1; cfg_ie = 1'b1;
    configure();
    wr(3'd0, ctrl_word(1'b1, 1'b1, 1'b1));
    repeat (40) idle();
    check("pre_reset_irq", 32'(irq), 32'd1);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset2_pwm", 32'(pwm_out), 32'd0);
    check("reset2_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 0, "reset_reg");
    idle();
    cur_duty = 0;

    // Steady PWM 3/10, then inverted 7/10
    cfg_p = 10; cfg_t = 3; cfg_s = 3; cfg_r = 0; cfg_pol = 1'b0; cfg_ie = 1'b1;
    build_seq(cur_duty, cfg_t, cfg_s);
    run_ramp(-1, 1'b0, -1, 0);
    wr(3'd0, ctrl_word(1'b1, 1'b1, 1'b1));
    repeat (3) idle();
    pwm_window("pwm_inverted", 10, 3, 1'b1);

    // Ramp down to 0
    cfg_p = 5; cfg_t = 0; cfg_s = 2; cfg_r = 0; cfg_pol = 1'b0; cfg_ie = 1'b0;
    build_seq(cur_duty, cfg_t, cfg_s);
    run_ramp(-1, 1'b0, -1, 0);

    // Ramp up with clamp 0->3->6->7, DONE cleared in the same cycle it sets
    cfg_p = 8; cfg_t = 7; cfg_s = 3; cfg_r = 1; cfg_pol = 1'b0; cfg_ie = 1'b1;
    build_seq(cur_duty, cfg_t, cfg_s);
    run_ramp(-1, 1'b1, -1, 0);
    wr(3'd5, 2);
    rd(3'd5, 0, "status_w1c");
    idle();
    check("irq_after_w1c", 32'(irq), 32'd0);

    // Climb to 20, then ramp down with a retarget to 12 while at 15
    cfg_p = 6; cfg_t = 20; cfg_s = 8; cfg_r = 0; cfg_pol = 1'b0; cfg_ie = 1'b1;
    build_seq(cur_duty, cfg_t, cfg_s);
    run_ramp(-1, 1'b0, -1, 0);
    cfg_t = 0; cfg_s = 5;
    seq_q.delete();
    seq_q.push_back(20); seq_q.push_back(15); seq_q.push_back(12);
    run_ramp(-1, 1'b0, cfg_p + 1, 12);

    // PERIOD=0: output pinned at POL while duty ramps to 5
    cfg_p = 0; cfg_t = 5; cfg_s = 5; cfg_r = 0; cfg_pol = 1'b1; cfg_ie = 1'b0;
    configure();
    wr(3'd0, ctrl_word(1'b1, 1'b0, 1'b1));
    for (int j = 0; j <= 30; j++) begin
      idle();
      check("pwm_period0", 32'(pwm_out), 32'd1);
    end
    rd(3'd6, 5, "duty_period0");
    idle();
    cur_duty = 5;

    // PERIOD rewritten mid-period: the running 8-cycle period completes first
    cfg_p = 8; cfg_t = 5; cfg_s = 1; cfg_r = 0; cfg_pol = 1'b0; cfg_ie = 1'b0;
    configure();
    wr(3'd0, ctrl_word(1'b0, 1'b0, 1'b1));
    for (int j = 0; j <= 20; j++) begin
      int c;
      if (j == 3) wr(3'd1, 4);
      else        idle();
      if (j >= 2) begin
        c = (j - 1 <= 8) ? (j - 2) : ((j - 1 - 9) % 4);
        check("pwm_period_change", 32'(pwm_out), 32'(c < 5));
      end
    end

    // Randomized ramps, some disabled mid-ramp and resumed
    last_trunc = 1'b0;
    for (int it = 0; it < 14; it++) begin
      if (!(last_trunc && $urandom_range(0, 1) == 1)) begin
        cfg_p   = $urandom_range(3, 10);
        cfg_t   = $urandom_range(0, 20);
        cfg_s   = $urandom_range(0, 5);
        cfg_r   = $urandom_range(0, 2);
        cfg_pol = 1'($urandom_range(0, 1));
        cfg_ie  = 1'($urandom_range(0, 1));
      end
      build_seq(cur_duty, cfg_t, cfg_s);
      n       = seq_q.size() - 1;
      q       = (cfg_r + 1) * cfg_p;
      trunc   = (n * q >= 3) && ($urandom_range(0, 2) == 0);
      jdis    = trunc ? int'($urandom_range(1, n * q - 1)) : -1;
      collide = !trunc && (n > 0) && ($urandom_range(0, 1) == 1);
      run_ramp(jdis, collide, -1, 0);
      last_trunc = trunc;
    end

    repeat (4) idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
